// File: rtl/clarvi_mem_arbiter.sv
// Two-to-one Avalon-MM arbiter: clarvi instruction port and data port share one 64-bit slave.
// Optional: define CLARVI_ARB_ROUND_ROBIN_EN for round-robin tie-break (default: data port wins ties).
module clarvi_mem_arbiter #(
   parameter int ADDR_WIDTH  = 14,
   parameter int MAX_PENDING = 4
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [ADDR_WIDTH-1:0] avs_instr_address,
   input  logic                  avs_instr_read,
   output logic [63:0]           avs_instr_readdata,
   output logic                  avs_instr_waitrequest,
   output logic                  avs_instr_readdatavalid,
   input  logic [ADDR_WIDTH-1:0] avs_data_address,
   input  logic [7:0]            avs_data_byteenable,
   input  logic                  avs_data_read,
   input  logic                  avs_data_write,
   input  logic [63:0]           avs_data_writedata,
   output logic [63:0]           avs_data_readdata,
   output logic                  avs_data_waitrequest,
   output logic                  avs_data_readdatavalid,
   output logic [ADDR_WIDTH-1:0] avm_mem_address,
   output logic [7:0]            avm_mem_byteenable,
   output logic                  avm_mem_read,
   output logic                  avm_mem_write,
   output logic [63:0]           avm_mem_writedata,
   input  logic [63:0]           avm_mem_readdata,
   input  logic                  avm_mem_waitrequest,
   input  logic                  avm_mem_readdatavalid,
   output logic                  arb_protocol_error
);

   localparam int          PW     = $clog2(MAX_PENDING);
   localparam logic [PW:0] DEPTH  = (PW+1)'(MAX_PENDING);
   localparam logic [PW:0] CNT1   = (PW+1)'(1);
   localparam logic [PW-1:0] PTR1 = PW'(1);

   typedef enum logic [1:0] {IDLE, HOLD_I, HOLD_D} state_t;

   state_t                 state_q, state_d;
   logic [MAX_PENDING-1:0] owner_q;
   logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW:0]            count_q, count_d;
   logic                   perr_q, perr_d;

   logic instr_req, data_req, gnt_i, gnt_d, tie_to_data;
   logic fifo_full, fifo_empty, push, pop, rd_ok, head;
   logic stall_i, stall_d, accepted;

   assign instr_req = avs_instr_read;
   assign data_req  = avs_data_read | avs_data_write;

`ifdef CLARVI_ARB_ROUND_ROBIN_EN
   logic last_data_q, last_data_d;
   assign tie_to_data = ~last_data_q;
   assign last_data_d = accepted ? gnt_d : last_data_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) last_data_q <= 1'b0;
      else          last_data_q <= last_data_d;
   end
`else
   assign tie_to_data = 1'b1;
`endif

   // A held grant belongs to its holder; dropping the request abandons it without a transfer.
   always_comb begin
      gnt_i = 1'b0;
      gnt_d = 1'b0;
      case (state_q)
         HOLD_I:  gnt_i = instr_req & reset_n;
         HOLD_D:  gnt_d = data_req & reset_n;
         default: begin
            if (instr_req && data_req) begin
               gnt_d = tie_to_data & reset_n;
               gnt_i = ~tie_to_data & reset_n;
            end else begin
               gnt_i = instr_req & reset_n;
               gnt_d = data_req & reset_n;
            end
         end
      endcase
   end

   assign fifo_full  = (count_q == DEPTH);
   assign fifo_empty = (count_q == '0);
   assign pop        = avm_mem_readdatavalid & ~fifo_empty;
   assign head       = owner_q[rd_ptr_q];
   // A full FIFO can still take a read in the cycle a beat frees a slot.
   assign rd_ok      = ~fifo_full | pop;

   assign avm_mem_address    = gnt_d ? avs_data_address : avs_instr_address;
   assign avm_mem_byteenable = gnt_d ? avs_data_byteenable : 8'hFF;
   assign avm_mem_writedata  = avs_data_writedata;
   assign avm_mem_read       = (gnt_i & rd_ok) | (gnt_d & avs_data_read & ~avs_data_write & rd_ok);
   assign avm_mem_write      = gnt_d & avs_data_write;

   assign accepted = (avm_mem_read | avm_mem_write) & ~avm_mem_waitrequest;
   assign push     = avm_mem_read & ~avm_mem_waitrequest;

   assign avs_instr_waitrequest = ~(gnt_i & ~avm_mem_waitrequest & rd_ok);
   assign avs_data_waitrequest  = ~(gnt_d & ~avm_mem_waitrequest & (avs_data_write | rd_ok));

   assign avs_instr_readdata      = avm_mem_readdata;
   assign avs_data_readdata       = avm_mem_readdata;
   assign avs_instr_readdatavalid = pop & ~head;
   assign avs_data_readdatavalid  = pop & head;
   assign arb_protocol_error      = perr_q;

   assign stall_i = avm_mem_waitrequest | ~rd_ok;
   assign stall_d = avm_mem_waitrequest | (~avs_data_write & ~rd_ok);

   always_comb begin
      state_d = IDLE;
      if (gnt_i && stall_i)      state_d = HOLD_I;
      else if (gnt_d && stall_d) state_d = HOLD_D;
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      perr_d   = perr_q | (avm_mem_readdatavalid & fifo_empty);
      if (push) wr_ptr_d = wr_ptr_q + PTR1;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR1;
      if (push && !pop)      count_d = count_q + CNT1;
      else if (pop && !push) count_d = count_q - CNT1;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         perr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         perr_q   <= perr_d;
      end
   end

   // Owner bit per outstanding read: 0 = instruction, 1 = data.
   always_ff @(posedge clock) begin
      if (push) owner_q[wr_ptr_q] <= gnt_d;
   end

endmodule

// File: tb/tb_clarvi_mem_arbiter.sv
// Directed bench for clarvi_mem_arbiter with a latency-programmable slave model and a read-return scoreboard.
module tb_clarvi_mem_arbiter;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [13:0] avs_instr_address;
   logic        avs_instr_read;
   logic [63:0] avs_instr_readdata;
   logic        avs_instr_waitrequest;
   logic        avs_instr_readdatavalid;
   logic [13:0] avs_data_address;
   logic [7:0]  avs_data_byteenable;
   logic        avs_data_read;
   logic        avs_data_write;
   logic [63:0] avs_data_writedata;
   logic [63:0] avs_data_readdata;
   logic        avs_data_waitrequest;
   logic        avs_data_readdatavalid;
   logic [13:0] avm_mem_address;
   logic [7:0]  avm_mem_byteenable;
   logic        avm_mem_read;
   logic        avm_mem_write;
   logic [63:0] avm_mem_writedata;
   logic [63:0] avm_mem_readdata;
   logic        avm_mem_waitrequest;
   logic        avm_mem_readdatavalid;
   logic        arb_protocol_error;

   clarvi_mem_arbiter dut (
      .clock                  (clock),
      .reset_n                (reset_n),
      .avs_instr_address      (avs_instr_address),
      .avs_instr_read         (avs_instr_read),
      .avs_instr_readdata     (avs_instr_readdata),
      .avs_instr_waitrequest  (avs_instr_waitrequest),
      .avs_instr_readdatavalid(avs_instr_readdatavalid),
      .avs_data_address       (avs_data_address),
      .avs_data_byteenable    (avs_data_byteenable),
      .avs_data_read          (avs_data_read),
      .avs_data_write         (avs_data_write),
      .avs_data_writedata     (avs_data_writedata),
      .avs_data_readdata      (avs_data_readdata),
      .avs_data_waitrequest   (avs_data_waitrequest),
      .avs_data_readdatavalid (avs_data_readdatavalid),
      .avm_mem_address        (avm_mem_address),
      .avm_mem_byteenable     (avm_mem_byteenable),
      .avm_mem_read           (avm_mem_read),
      .avm_mem_write          (avm_mem_write),
      .avm_mem_writedata      (avm_mem_writedata),
      .avm_mem_readdata       (avm_mem_readdata),
      .avm_mem_waitrequest    (avm_mem_waitrequest),
      .avm_mem_readdatavalid  (avm_mem_readdatavalid),
      .arb_protocol_error     (arb_protocol_error)
   );

   always #5 clock = ~clock;

   typedef struct {logic port; logic [63:0] d;} sb_t;
   typedef struct {int due; logic [63:0] d;} sl_t;

   sb_t sb[$];
   sl_t slv[$];
   int  errors, checks, cycle, lat;
   logic exp_ig;

   function automatic logic [63:0] mdata(input logic [13:0] a);
      if (a == 14'h010) return 64'h1122334455667788;
      return 64'hD0D0_0000_0000_0000 | {50'h0, a};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive_idle();
      avs_instr_read = 1'b0;
      avs_data_read  = 1'b0;
      avs_data_write = 1'b0;
   endtask

   // One clock: observe handshakes and returns, advance, then let the slave model drive its beat.
   task automatic cyc();
      sb_t e;
      #1;
      if (avm_mem_readdatavalid) begin
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("rdv_route", {62'h0, avs_instr_readdatavalid, avs_data_readdatavalid},
                e.port ? 64'h1 : 64'h2);
            chk("rdv_data", e.port ? avs_data_readdata : avs_instr_readdata, e.d);
         end else begin
            chk("rdv_dropped", {62'h0, avs_instr_readdatavalid, avs_data_readdatavalid}, 64'h0);
         end
      end else if (avs_instr_readdatavalid || avs_data_readdatavalid) begin
         chk("rdv_spurious", {62'h0, avs_instr_readdatavalid, avs_data_readdatavalid}, 64'h0);
      end
      if (avs_instr_read && !avs_instr_waitrequest)
         sb.push_back('{1'b0, mdata(avs_instr_address)});
      if (avs_data_read && !avs_data_write && !avs_data_waitrequest)
         sb.push_back('{1'b1, mdata(avs_data_address)});
      if (avm_mem_read && !avm_mem_waitrequest)
         slv.push_back('{cycle + lat, mdata(avm_mem_address)});
      @(posedge clock);
      cycle++;
      #1;
      avm_mem_readdatavalid = 1'b0;
      avm_mem_readdata      = 64'h0;
      if (slv.size() > 0 && slv[0].due == cycle) begin
         avm_mem_readdatavalid = 1'b1;
         avm_mem_readdata      = slv[0].d;
         void'(slv.pop_front());
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      drive_idle();
      while ((sb.size() > 0 || slv.size() > 0 || avm_mem_readdatavalid) && n < 40) begin
         cyc();
         n++;
      end
      chk("drain_outstanding", 64'(sb.size()), 64'h0);
   endtask

   initial begin
      errors = 0; checks = 0; cycle = 0; lat = 1;
      reset_n = 1'b0;
      avs_instr_address = '0; avs_data_address = '0;
      avs_data_byteenable = '0; avs_data_writedata = '0;
      avm_mem_waitrequest = 1'b0; avm_mem_readdata = '0;
      avs_instr_read = 1'b1; avs_data_read = 1'b0; avs_data_write = 1'b1;
      avm_mem_readdatavalid = 1'b1;
      #2;
      chk("rst_mem_read", avm_mem_read, 1'b0);
      chk("rst_mem_write", avm_mem_write, 1'b0);
      chk("rst_instr_wait", avs_instr_waitrequest, 1'b1);
      chk("rst_data_wait", avs_data_waitrequest, 1'b1);
      chk("rst_instr_rdv", avs_instr_readdatavalid, 1'b0);
      chk("rst_data_rdv", avs_data_readdatavalid, 1'b0);
      chk("rst_perr", arb_protocol_error, 1'b0);
      drive_idle();
      avm_mem_readdatavalid = 1'b0;
      @(posedge clock); #1;
      reset_n = 1'b1;
      #1;
      chk("rel_perr", arb_protocol_error, 1'b0);

      // Single instruction read, latency 1
      avs_instr_read = 1'b1; avs_instr_address = 14'h010;
      #1;
      chk("t1_mem_read", avm_mem_read, 1'b1);
      chk("t1_addr", avm_mem_address, 14'h010);
      chk("t1_be", avm_mem_byteenable, 8'hFF);
      chk("t1_mem_write", avm_mem_write, 1'b0);
      chk("t1_instr_wait", avs_instr_waitrequest, 1'b0);
      cyc();
      drive_idle();
      #1;
      chk("t1_instr_rdv", avs_instr_readdatavalid, 1'b1);
      chk("t1_rdata", avs_instr_readdata, 64'h1122334455667788);
      chk("t1_data_rdv", avs_data_readdatavalid, 1'b0);
      drain();

      // Simultaneous instr read and data write: data first, then instr
      avs_instr_read = 1'b1; avs_instr_address = 14'h020;
      avs_data_write = 1'b1; avs_data_address = 14'h030;
      avs_data_byteenable = 8'h0F; avs_data_writedata = 64'hCAFE_F00D_1234_5678;
      #1;
      chk("t2_mem_write", avm_mem_write, 1'b1);
      chk("t2_mem_read", avm_mem_read, 1'b0);
      chk("t2_addr_d", avm_mem_address, 14'h030);
      chk("t2_be_d", avm_mem_byteenable, 8'h0F);
      chk("t2_wdata", avm_mem_writedata, 64'hCAFE_F00D_1234_5678);
      chk("t2_data_wait", avs_data_waitrequest, 1'b0);
      chk("t2_instr_wait", avs_instr_waitrequest, 1'b1);
      cyc();
      avs_data_write = 1'b0;
      #1;
      chk("t2_addr_i", avm_mem_address, 14'h020);
      chk("t2_mem_read_i", avm_mem_read, 1'b1);
      chk("t2_be_i", avm_mem_byteenable, 8'hFF);
      chk("t2_instr_wait_i", avs_instr_waitrequest, 1'b0);
      cyc();
      // Continued contention
      avs_instr_address = 14'h021;
      avs_data_read = 1'b1; avs_data_address = 14'h031;
      for (int k = 0; k < 3; k++) begin
         #1;
`ifdef CLARVI_ARB_ROUND_ROBIN_EN
         exp_ig = (k == 1);
`else
         exp_ig = 1'b0;
`endif
         chk("t2_tie_instr_wait", avs_instr_waitrequest, !exp_ig);
         chk("t2_tie_data_wait", avs_data_waitrequest, exp_ig);
         cyc();
      end
      drain();

      // Slave stalls a data read for 3 cycles while instr requests
      lat = 2;
      avs_data_read = 1'b1; avs_data_address = 14'h040;
      avm_mem_waitrequest = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (k == 1) begin avs_instr_read = 1'b1; avs_instr_address = 14'h050; end
         if (k == 3) avm_mem_waitrequest = 1'b0;
         #1;
         chk("t3_addr_stable", avm_mem_address, 14'h040);
         chk("t3_read_stable", avm_mem_read, 1'b1);
         chk("t3_instr_wait", avs_instr_waitrequest, 1'b1);
         chk("t3_data_wait", avs_data_waitrequest, (k == 3) ? 1'b0 : 1'b1);
         cyc();
      end
      avs_data_read = 1'b0;
      #1;
      chk("t3_instr_next_addr", avm_mem_address, 14'h050);
      chk("t3_instr_next_wait", avs_instr_waitrequest, 1'b0);
      cyc();
      drain();

      // Owner FIFO full: latency 8, six back-to-back instr reads
      lat = 8;
      avs_instr_read = 1'b1;
      for (int k = 0; k < 4; k++) begin
         avs_instr_address = 14'h100 + 14'(k);
         #1;
         chk("t4_accept_read", avm_mem_read, 1'b1);
         chk("t4_accept_wait", avs_instr_waitrequest, 1'b0);
         cyc();
      end
      avs_instr_address = 14'h104;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("t4_full_read", avm_mem_read, 1'b0);
         chk("t4_full_wait", avs_instr_waitrequest, 1'b1);
         cyc();
      end
      #1;
      chk("t4_pop_read", avm_mem_read, 1'b1);
      chk("t4_pop_wait", avs_instr_waitrequest, 1'b0);
      cyc();
      avs_instr_address = 14'h105;
      #1;
      chk("t4_sixth_wait", avs_instr_waitrequest, 1'b0);
      cyc();
      drain();

      // Interleaved I,D,I,D reads, latency 3
      lat = 3;
      for (int k = 0; k < 4; k++) begin
         drive_idle();
         if (k % 2 == 0) begin
            avs_instr_read = 1'b1; avs_instr_address = 14'h200 + 14'(k);
         end else begin
            avs_data_read = 1'b1; avs_data_address = 14'h300 + 14'(k);
         end
         #1;
         chk("t5_issue_read", avm_mem_read, 1'b1);
         chk("t5_issue_wait", (k % 2 == 0) ? avs_instr_waitrequest : avs_data_waitrequest, 1'b0);
         cyc();
      end
      drain();

      // Readdatavalid with nothing outstanding
      avm_mem_readdatavalid = 1'b1; avm_mem_readdata = 64'hDEAD;
      #1;
      chk("t6_drop_instr_rdv", avs_instr_readdatavalid, 1'b0);
      chk("t6_drop_data_rdv", avs_data_readdatavalid, 1'b0);
      chk("t6_perr_pre", arb_protocol_error, 1'b0);
      cyc();
      #1;
      chk("t6_perr_set", arb_protocol_error, 1'b1);
      cyc(); cyc();
      #1;
      chk("t6_perr_sticky", arb_protocol_error, 1'b1);
      reset_n = 1'b0;
      #1;
      chk("t6_perr_reset", arb_protocol_error, 1'b0);
      cyc();
      reset_n = 1'b1;
      #1;
      chk("t6_perr_after", arb_protocol_error, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
